hex_latch_arbiter: RTL and testbench
====================================

Name: hex_latch_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared external 6-bit hex D-latch bank (LS174-class: rising-edge clock, active-low clear).
- Grants one of NREQ requesters per transaction and presents its data with one cycle of setup before the strobe and one cycle of hold after it.
- Also sequences a timed clear of the bank on request.
- Sits between video/sound control logic and the discrete register models.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- CLR_CYCLES, 2, number of cycles _LD_CLR_N is held low during a clear operation; legal range 1..15.

Ports:
- _CLK  input  1  system clock, rising edge.
- _RST  input  1  asynchronous active-high reset.
- _REQ  input  NREQ  per-requester write request, level.
- _DIN  input  6*NREQ  requester data; requester i uses bits [6i+5:6i].
- _CLRREQ  input  1  clear request, level.
- _GNT  output  NREQ  one-hot grant.
- _ACK  output  NREQ  one-hot, one-cycle write-complete pulse.
- _CLRDONE  output  1  one-cycle pulse when a clear completes.
- _BUSY  output  1  high in any state other than IDLE.
- _LD_D  output  6  data to the latch bank D inputs.
- _LD_STB  output  1  clock/strobe to the latch bank; one-cycle pulse.
- _LD_CLR_N  output  1  active-low clear to the latch bank.

Behaviour:
- All outputs are registered.
- Reset values:
  - state IDLE, rr pointer 0.
  - _GNT, _ACK, _CLRDONE, _BUSY, _LD_STB and _LD_D are all 0.
  - _LD_CLR_N is 0, so the bank is held clear during reset.
- After _RST falls, _LD_CLR_N rises at the first _CLK edge.
- States: IDLE, SETUP, STROBE, HOLD, CLEAR.
- IDLE:
  - If _CLRREQ=1, go to CLEAR. Clear has priority over _REQ.
  - Else if any _REQ=1, select the first requesting index searching upward from the rr pointer, wrapping modulo NREQ.
  - On selection: register that requester's slice onto _LD_D, set _GNT one-hot, and go to SETUP.
- SETUP: _LD_D stable, _LD_STB=0; next state STROBE.
- STROBE: _LD_STB=1 for exactly this cycle, _LD_D unchanged; next state HOLD.
- HOLD:
  - _LD_STB=0 and _LD_D unchanged (one hold cycle).
  - _ACK[i]=1 for this cycle.
  - rr pointer becomes (i+1) mod NREQ.
  - Next state IDLE; _GNT clears on entry to IDLE.
- Latency:
  - _REQ sampled in IDLE at cycle 0 gives _GNT at cycle 1, _LD_STB at cycle 2 and _ACK at cycle 3.
  - Back-to-back throughput is one write per 4 cycles.
- _DIN is sampled only at grant; later changes to _DIN are ignored.
- Requester deasserting _REQ:
  - A deassert after grant does not abort the transaction.
  - A _REQ still high in IDLE after _ACK is treated as a new request, behind the others in rr order.
- CLEAR:
  - _LD_CLR_N=0 for CLR_CYCLES cycles, counted by an internal down-counter.
  - Then return to IDLE with _LD_CLR_N=1 and _CLRDONE=1 for one cycle.
  - _CLRREQ is level: if it is still high in IDLE, another clear runs.
- _CLRREQ asserted mid-transaction: the transaction completes, and the clear is taken in the next IDLE.
- _LD_D is not altered by a clear.
- Reset mid-operation aborts immediately to the reset values, including _LD_STB=0.
- Simultaneous _CLRREQ and _REQ in IDLE: clear first, then the write on the following IDLE.
- All-zero _REQ in IDLE: remain in IDLE, no outputs change.

Optional Feature:
- Macro: HEX_LATCH_SHADOW_EN.
- When defined:
  - Adds output port _SHADOW [5:0] mirroring the latch bank contents.
  - Adds output _SHADOW_OWNER [2:0], the index of the last writer.
  - _SHADOW loads _LD_D in the STROBE cycle, visible the next cycle.
  - A clear forces _SHADOW=0 and _SHADOW_OWNER=0 in the first CLEAR cycle.
  - Both reset to 0.
- When undefined: both ports and the logic behind them are absent; all other behaviour is identical.

Test Plan:
- Reset then single write: _REQ=4'b0100, _DIN slice2=6'h2A. Expect _GNT=4'b0100 at cycle 1, _LD_STB high at cycle 2 only with _LD_D=6'h2A from cycle 1 to 3, _ACK=4'b0100 at cycle 3.
- Round-robin: _REQ=4'b1111 held. Grants in order 0,1,2,3,0, spaced 4 cycles apart; each _LD_D matches the slice (6'h01,6'h02,6'h03,6'h04).
- Clear priority: _CLRREQ=1 and _REQ=4'b0001 together in IDLE, CLR_CYCLES=2. Expect _LD_CLR_N low for 2 cycles, then _CLRDONE pulse, then the write to requester 0 starts.
- Clear mid-transaction: _CLRREQ rises during STROBE. Expect _ACK in HOLD, then CLEAR; no strobe occurs while _LD_CLR_N=0.
- Reset mid-write: assert _RST during STROBE. Expect _LD_STB=0, _GNT=0 and _LD_CLR_N=0 immediately; rr pointer returns to 0 and the next grant goes to the lowest requesting index.
- With HEX_LATCH_SHADOW_EN: write 6'h15 from requester 3, then clear. Expect _SHADOW=6'h15 and _SHADOW_OWNER=3 after the strobe, then 0 and 0 after the clear.

Source files
------------

// File: rtl/hex_latch_arbiter.sv
// Round-robin arbiter and write sequencer for a shared 6-bit hex D-latch bank.
// Optional latch-content shadow ports are enabled by defining HEX_LATCH_SHADOW_EN.
module hex_latch_arbiter #(
   parameter int NREQ       = 4,
   parameter int CLR_CYCLES = 2
) (
   input  logic              _CLK,
   input  logic              _RST,
   input  logic [NREQ-1:0]   _REQ,
   input  logic [6*NREQ-1:0] _DIN,
   input  logic              _CLRREQ,
   output logic [NREQ-1:0]   _GNT,
   output logic [NREQ-1:0]   _ACK,
   output logic              _CLRDONE,
   output logic              _BUSY,
   output logic [5:0]        _LD_D,
   output logic              _LD_STB,
   output logic              _LD_CLR_N
`ifdef HEX_LATCH_SHADOW_EN
   ,
   output logic [5:0]        _SHADOW,
   output logic [2:0]        _SHADOW_OWNER
`endif
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETUP  = 3'd1,
      STROBE = 3'd2,
      HOLD   = 3'd3,
      CLEAR  = 3'd4
   } state_t;

   state_t          state_r;
   logic [2:0]      rr_r;
   logic [2:0]      idx_r;
   logic [3:0]      cnt_r;

   logic            hi_found_s;
   logic            lo_found_s;
   logic [2:0]      hi_idx_s;
   logic [2:0]      lo_idx_s;
   logic [5:0]      hi_data_s;
   logic [5:0]      lo_data_s;
   logic            sel_found_s;
   logic [2:0]      sel_idx_s;
   logic [5:0]      sel_data_s;
   logic [NREQ-1:0] onehot_s;

   // Round-robin pick: lowest requester at or above rr_r, else lowest overall (wrap).
   always_comb begin
      hi_found_s = 1'b0;
      lo_found_s = 1'b0;
      hi_idx_s   = 3'd0;
      lo_idx_s   = 3'd0;
      hi_data_s  = 6'd0;
      lo_data_s  = 6'd0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (_REQ[i]) begin
            lo_found_s = 1'b1;
            lo_idx_s   = 3'(i);
            lo_data_s  = _DIN[6*i +: 6];
            if (3'(i) >= rr_r) begin
               hi_found_s = 1'b1;
               hi_idx_s   = 3'(i);
               hi_data_s  = _DIN[6*i +: 6];
            end else begin
               hi_found_s = hi_found_s;
            end
         end else begin
            lo_found_s = lo_found_s;
         end
      end
      sel_found_s = lo_found_s;
      sel_idx_s   = hi_found_s ? hi_idx_s  : lo_idx_s;
      sel_data_s  = hi_found_s ? hi_data_s : lo_data_s;
   end

   // One-hot decode of the selected requester.
   always_comb begin
      onehot_s = '0;
      for (int i = 0; i < NREQ; i++) begin
         onehot_s[i] = (sel_idx_s == 3'(i));
      end
   end

   // Sequencer FSM; every output is a register updated on the state transition.
   always_ff @(posedge _CLK or posedge _RST) begin
      if (_RST) begin
         state_r   <= IDLE;
         rr_r      <= 3'd0;
         idx_r     <= 3'd0;
         cnt_r     <= 4'd0;
         _GNT      <= '0;
         _ACK      <= '0;
         _CLRDONE  <= 1'b0;
         _BUSY     <= 1'b0;
         _LD_D     <= 6'd0;
         _LD_STB   <= 1'b0;
         _LD_CLR_N <= 1'b0;
`ifdef HEX_LATCH_SHADOW_EN
         _SHADOW       <= 6'd0;
         _SHADOW_OWNER <= 3'd0;
`endif
      end else begin
         _ACK      <= '0;
         _CLRDONE  <= 1'b0;
         _LD_STB   <= 1'b0;
         _LD_CLR_N <= 1'b1;
         case (state_r)
            IDLE: begin
               if (_CLRREQ) begin
                  state_r   <= CLEAR;
                  cnt_r     <= 4'(CLR_CYCLES - 1);
                  _LD_CLR_N <= 1'b0;
                  _BUSY     <= 1'b1;
`ifdef HEX_LATCH_SHADOW_EN
                  _SHADOW       <= 6'd0;
                  _SHADOW_OWNER <= 3'd0;
`endif
               end else if (sel_found_s) begin
                  state_r <= SETUP;
                  idx_r   <= sel_idx_s;
                  _LD_D   <= sel_data_s;
                  _GNT    <= onehot_s;
                  _BUSY   <= 1'b1;
               end else begin
                  _BUSY <= 1'b0;
               end
            end
            SETUP: begin
               state_r <= STROBE;
               _LD_STB <= 1'b1;
            end
            STROBE: begin
               state_r <= HOLD;
               _ACK    <= _GNT;
`ifdef HEX_LATCH_SHADOW_EN
               _SHADOW       <= _LD_D;
               _SHADOW_OWNER <= idx_r;
`endif
            end
            HOLD: begin
               state_r <= IDLE;
               rr_r    <= (idx_r == 3'(NREQ - 1)) ? 3'd0 : idx_r + 3'd1;
               _GNT    <= '0;
               _BUSY   <= 1'b0;
            end
            CLEAR: begin
               if (cnt_r == 4'd0) begin
                  state_r  <= IDLE;
                  _CLRDONE <= 1'b1;
                  _BUSY    <= 1'b0;
               end else begin
                  cnt_r     <= cnt_r - 4'd1;
                  _LD_CLR_N <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               _GNT    <= '0;
               _BUSY   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hex_latch_arbiter.sv
// Self-checking bench for hex_latch_arbiter: scenario tasks with a queue of expected writes.
module tb_hex_latch_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [23:0] din;
   logic        clrreq;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic        clrdone;
   logic        busy;
   logic [5:0]  ld_d;
   logic        ld_stb;
   logic        ld_clr_n;
`ifdef HEX_LATCH_SHADOW_EN
   logic [5:0]  shadow;
   logic [2:0]  shadow_owner;
`endif

   typedef struct {
      int         idx;
      logic [5:0] data;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   hex_latch_arbiter #(.NREQ(4), .CLR_CYCLES(2)) dut (
      ._CLK(clk), ._RST(rst), ._REQ(req), ._DIN(din), ._CLRREQ(clrreq),
      ._GNT(gnt), ._ACK(ack), ._CLRDONE(clrdone), ._BUSY(busy),
      ._LD_D(ld_d), ._LD_STB(ld_stb), ._LD_CLR_N(ld_clr_n)
`ifdef HEX_LATCH_SHADOW_EN
      , ._SHADOW(shadow), ._SHADOW_OWNER(shadow_owner)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = 4'b0000; clrreq = 1'b0;
      tick();
      @(posedge clk); #3;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b0000; din = 24'h0; clrreq = 1'b0;
      tick(); tick();
      n_cmp++; if (gnt !== 4'b0000)  begin n_bad++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
      n_cmp++; if (ack !== 4'b0000)  begin n_bad++; $display("FAIL rst_ack got=%b exp=0000", ack); end
      n_cmp++; if (clrdone !== 1'b0) begin n_bad++; $display("FAIL rst_clrdone got=%b exp=0", clrdone); end
      n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      n_cmp++; if (ld_stb !== 1'b0)  begin n_bad++; $display("FAIL rst_stb got=%b exp=0", ld_stb); end
      n_cmp++; if (ld_d !== 6'h00)   begin n_bad++; $display("FAIL rst_ld_d got=%h exp=00", ld_d); end
      n_cmp++; if (ld_clr_n !== 1'b0) begin n_bad++; $display("FAIL rst_clr_n got=%b exp=0", ld_clr_n); end
      #3 rst = 1'b0;
      #2;
      n_cmp++; if (ld_clr_n !== 1'b0) begin n_bad++; $display("FAIL rst_clr_n_before_edge got=%b exp=0", ld_clr_n); end
      tick();
      n_cmp++; if (ld_clr_n !== 1'b1) begin n_bad++; $display("FAIL rst_clr_n_after_edge got=%b exp=1", ld_clr_n); end
      for (int t = 0; t < 3; t++) begin
         tick();
         n_cmp++; if (busy !== 1'b0 || gnt !== 4'b0000) begin n_bad++; $display("FAIL idle_noreq busy=%b gnt=%b exp busy=0 gnt=0000", busy, gnt); end
      end
   endtask

   task automatic test_single_write();
      din = {6'h07, 6'h2A, 6'h05, 6'h06};
      req = 4'b0100;
      sb.push_back('{2, 6'h2A});
      tick();
      n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
      n_cmp++; if (ld_d !== 6'h2A)  begin n_bad++; $display("FAIL single_ld_d_c1 got=%h exp=2a", ld_d); end
      n_cmp++; if (ld_stb !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL single_c1 stb=%b busy=%b exp stb=0 busy=1", ld_stb, busy); end
      req = 4'b0000;
      din = {6'h07, 6'h3F, 6'h05, 6'h06};
      tick();
      n_cmp++; if (ld_stb !== 1'b1) begin n_bad++; $display("FAIL single_stb got=%b exp=1", ld_stb); end
      if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL single_sb_empty got=0 exp=1 entries"); end
      else begin
         e = sb.pop_front();
         n_cmp++; if (ld_d !== e.data) begin n_bad++; $display("FAIL single_ld_d_c2 got=%h exp=%h", ld_d, e.data); end
      end
      tick();
      n_cmp++; if (ack !== 4'b0100 || ld_stb !== 1'b0) begin n_bad++; $display("FAIL single_ack got ack=%b stb=%b exp ack=0100 stb=0", ack, ld_stb); end
      n_cmp++; if (ld_d !== 6'h2A) begin n_bad++; $display("FAIL single_ld_d_c3 got=%h exp=2a", ld_d); end
      tick();
      n_cmp++; if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0) begin n_bad++; $display("FAIL single_c4 gnt=%b ack=%b busy=%b exp 0000 0000 0", gnt, ack, busy); end
   endtask

   task automatic test_round_robin();
      int last_cyc;
      int order[5] = '{0, 1, 2, 3, 0};
      do_reset();
      din = {6'h04, 6'h03, 6'h02, 6'h01};
      req = 4'b1111;
      for (int n = 0; n < 5; n++) sb.push_back('{order[n], 6'(order[n] + 1)});
      last_cyc = 0;
      for (int n = 0; n < 5; n++) begin
         for (int t = 0; t < 12 && gnt == 4'b0000; t++) tick();
         if (gnt == 4'b0000) begin n_cmp++; n_bad++; $display("FAIL rr_timeout got=no_grant exp=grant n=%0d", n); break; end
         if (n > 0) begin
            n_cmp++; if (cyc - last_cyc != 4) begin n_bad++; $display("FAIL rr_spacing got=%0d exp=4", cyc - last_cyc); end
         end
         last_cyc = cyc;
         if (n == 4) req = 4'b0000;
         tick();
         if (sb.size() == 0) begin n_cmp++; n_bad++; $display("FAIL rr_sb_empty got=0 exp=1 entries"); end
         else begin
            e = sb.pop_front();
            n_cmp++; if (gnt !== (4'b0001 << e.idx)) begin n_bad++; $display("FAIL rr_gnt got=%b exp=%b", gnt, 4'b0001 << e.idx); end
            n_cmp++; if (ld_d !== e.data || ld_stb !== 1'b1) begin n_bad++; $display("FAIL rr_data got d=%h stb=%b exp d=%h stb=1", ld_d, ld_stb, e.data); end
            tick();
            n_cmp++; if (ack !== (4'b0001 << e.idx)) begin n_bad++; $display("FAIL rr_ack got=%b exp=%b", ack, 4'b0001 << e.idx); end
         end
         tick();
      end
   endtask

   task automatic test_clear_priority();
      do_reset();
      din = {6'h04, 6'h03, 6'h02, 6'h11};
      req = 4'b0001; clrreq = 1'b1;
      sb.push_back('{0, 6'h11});
      tick();
      n_cmp++; if (ld_clr_n !== 1'b0 || busy !== 1'b1 || gnt !== 4'b0000) begin n_bad++; $display("FAIL clrp_c1 clr_n=%b busy=%b gnt=%b exp 0 1 0000", ld_clr_n, busy, gnt); end
      clrreq = 1'b0;
      tick();
      n_cmp++; if (ld_clr_n !== 1'b0) begin n_bad++; $display("FAIL clrp_c2 clr_n got=%b exp=0", ld_clr_n); end
      tick();
      n_cmp++; if (ld_clr_n !== 1'b1 || clrdone !== 1'b1 || gnt !== 4'b0000) begin n_bad++; $display("FAIL clrp_done clr_n=%b done=%b gnt=%b exp 1 1 0000", ld_clr_n, clrdone, gnt); end
      tick();
      n_cmp++; if (gnt !== 4'b0001 || clrdone !== 1'b0) begin n_bad++; $display("FAIL clrp_gnt gnt=%b done=%b exp 0001 0", gnt, clrdone); end
      req = 4'b0000;
      tick();
      e = sb.pop_front();
      n_cmp++; if (ld_stb !== 1'b1 || ld_d !== e.data) begin n_bad++; $display("FAIL clrp_stb stb=%b d=%h exp 1 %h", ld_stb, ld_d, e.data); end
      tick();
      n_cmp++; if (ack !== 4'b0001) begin n_bad++; $display("FAIL clrp_ack got=%b exp=0001", ack); end
      tick();
   endtask

   task automatic test_clear_mid();
      int nlow;
      din = {6'h04, 6'h03, 6'h22, 6'h11};
      req = 4'b0010;
      sb.push_back('{1, 6'h22});
      tick();
      n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL clrm_gnt got=%b exp=0010", gnt); end
      req = 4'b0000;
      tick();
      e = sb.pop_front();
      n_cmp++; if (ld_stb !== 1'b1 || ld_d !== e.data) begin n_bad++; $display("FAIL clrm_stb stb=%b d=%h exp 1 %h", ld_stb, ld_d, e.data); end
      clrreq = 1'b1;
      tick();
      n_cmp++; if (ack !== 4'b0010 || ld_clr_n !== 1'b1) begin n_bad++; $display("FAIL clrm_hold ack=%b clr_n=%b exp 0010 1", ack, ld_clr_n); end
      tick();
      n_cmp++; if (busy !== 1'b0 || ld_clr_n !== 1'b1) begin n_bad++; $display("FAIL clrm_idle busy=%b clr_n=%b exp 0 1", busy, ld_clr_n); end
      tick();
      clrreq = 1'b0;
      nlow = 0;
      for (int t = 0; t < 10 && ld_clr_n == 1'b0; t++) begin
         n_cmp++; if (ld_stb !== 1'b0 || ld_d !== 6'h22) begin n_bad++; $display("FAIL clrm_during stb=%b d=%h exp 0 22", ld_stb, ld_d); end
         nlow++;
         tick();
      end
      n_cmp++; if (nlow != 2) begin n_bad++; $display("FAIL clrm_len got=%0d exp=2", nlow); end
      n_cmp++; if (clrdone !== 1'b1 || ld_d !== 6'h22) begin n_bad++; $display("FAIL clrm_done done=%b d=%h exp 1 22", clrdone, ld_d); end
      tick();
   endtask

   task automatic test_reset_mid();
      din = {6'h04, 6'h0B, 6'h0A, 6'h11};
      req = 4'b0110;
      sb.push_back('{2, 6'h0B});
      tick();
      n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL rmid_gnt got=%b exp=0100", gnt); end
      tick();
      e = sb.pop_front();
      n_cmp++; if (ld_stb !== 1'b1 || ld_d !== e.data) begin n_bad++; $display("FAIL rmid_stb stb=%b d=%h exp 1 %h", ld_stb, ld_d, e.data); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (ld_stb !== 1'b0 || gnt !== 4'b0000 || ld_clr_n !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_abort stb=%b gnt=%b clr_n=%b busy=%b exp 0 0000 0 0", ld_stb, gnt, ld_clr_n, busy); end
      #2 rst = 1'b0;
      sb.push_back('{1, 6'h0A});
      tick();
      n_cmp++; if (gnt !== 4'b0010 || ld_clr_n !== 1'b1) begin n_bad++; $display("FAIL rmid_regrant gnt=%b clr_n=%b exp 0010 1", gnt, ld_clr_n); end
      req = 4'b0000;
      tick();
      e = sb.pop_front();
      n_cmp++; if (ld_stb !== 1'b1 || ld_d !== e.data) begin n_bad++; $display("FAIL rmid_stb2 stb=%b d=%h exp 1 %h", ld_stb, ld_d, e.data); end
      tick();
      n_cmp++; if (ack !== 4'b0010) begin n_bad++; $display("FAIL rmid_ack got=%b exp=0010", ack); end
      tick();
   endtask

`ifdef HEX_LATCH_SHADOW_EN
   task automatic test_shadow();
      do_reset();
      din = {6'h15, 6'h03, 6'h02, 6'h01};
      req = 4'b1000;
      tick();
      req = 4'b0000;
      tick(); tick();
      n_cmp++; if (shadow !== 6'h15 || shadow_owner !== 3'd3) begin n_bad++; $display("FAIL shadow_write got=%h/%0d exp=15/3", shadow, shadow_owner); end
      tick();
      clrreq = 1'b1;
      tick();
      clrreq = 1'b0;
      n_cmp++; if (shadow !== 6'h00 || shadow_owner !== 3'd0) begin n_bad++; $display("FAIL shadow_clear got=%h/%0d exp=00/0", shadow, shadow_owner); end
      tick(); tick();
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_round_robin();
      test_clear_priority();
      test_clear_mid();
      test_reset_mid();
`ifdef HEX_LATCH_SHADOW_EN
      test_shadow();
`endif
      n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
